ifu_fetch_ctrl: RTL and testbench



---
 rtl/ifu_fetch_ctrl.sv | 179 +++++++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: instruction fetch controller.
// Issues one instruction-memory request at a time. It looks up the BPU in the
// grant cycle and takes the predicted next PC one cycle later. Returned words go
// into a 2-entry fetch buffer toward decode. A redirect from the ALU flushes
// the buffer and steers the PC. Any response still in flight is drained and
// dropped.
//
// Ports
//   clk                       clock, all state on rising edge
//   rstn                      synchronous reset, active HIGH despite the name
//   bpu_ifu_next_pc/_predict_taken/_predict_pc   BPU result, cycle after lookup
//   alu_ifu_redirect/_redirect_pc                redirect pulse and target
//   imem_ifu_gnt/_rvalid/_rdata                  instruction memory handshake
//   idu_ifu_ready             decode accepts the buffer head
//   ifu_bpu_pc_valid/_pc      BTB lookup strobe and PC
//   ifu_bpu_hit_vld           a prediction was consumed by a returned fetch
//   ifu_imem_req/_addr        fetch request, word aligned
//   ifu_idu_*                 buffer head toward decode
//
// state | meaning
// ------+-------------------------------------------------------------
// REQ   | request asserted, waiting for grant
// WAIT  | one request outstanding, waiting for rvalid
// STALL | buffer full, no request until decode frees an entry
// DRAIN | redirected while outstanding; drop the response when it comes
module ifu_fetch_ctrl #(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] bpu_ifu_next_pc,
    input  logic        bpu_ifu_predict_taken,
    input  logic [63:0] bpu_ifu_predict_pc,
    input  logic        alu_ifu_redirect,
    input  logic [63:0] alu_ifu_redirect_pc,
    input  logic        imem_ifu_gnt,
    input  logic        imem_ifu_rvalid,
    input  logic [31:0] imem_ifu_rdata,
    input  logic        idu_ifu_ready,
    output logic        ifu_bpu_pc_valid,
    output logic [63:0] ifu_bpu_pc,
    output logic        ifu_bpu_hit_vld,
    output logic        ifu_imem_req,
    output logic [63:0] ifu_imem_addr,
    output logic        ifu_idu_valid,
    output logic [63:0] ifu_idu_pc,
    output logic [31:0] ifu_idu_inst,
    output logic        ifu_idu_predict_taken,
    output logic [63:0] ifu_idu_predict_pc
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [1:0] FIFO_FULL = 2'(FIFO_DEPTH);

    logic [1:0]  state_q, state_d;
    logic [63:0] pc_q;
    logic [63:0] fetch_pc_q;
    logic        capture_q;
    logic        side_taken_q;
    logic [63:0] side_ppc_q;

    logic [63:0] fifo_pc    [2];
    logic [31:0] fifo_inst  [2];
    logic        fifo_taken [2];
    logic [63:0] fifo_ppc   [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q, count_after;

    logic run;
    logic grant;
    logic push;
    logic pop;
    logic push_taken;
    logic [63:0] push_ppc;

    assign run   = ~rstn;
    assign grant = (state_q == S_REQ) & imem_ifu_gnt;
    // A redirect in the response cycle kills the response outright.
    assign push  = (state_q == S_WAIT) & imem_ifu_rvalid & ~alu_ifu_redirect;

    // When rvalid lands in the capture cycle the side register is not loaded
    // yet, so the prediction comes straight from the BPU inputs.
    assign push_taken = capture_q ? bpu_ifu_predict_taken : side_taken_q;
    assign push_ppc   = capture_q ? bpu_ifu_predict_pc    : side_ppc_q;

    assign ifu_imem_req     = run & (state_q == S_REQ);
    assign ifu_imem_addr    = {pc_q[63:2], 2'b00};
    assign ifu_bpu_pc_valid = run & grant;
    assign ifu_bpu_pc       = pc_q;
    assign ifu_bpu_hit_vld  = run & push;

    assign ifu_idu_valid         = run & (count_q != 2'd0) & ~alu_ifu_redirect;
    assign ifu_idu_pc            = fifo_pc[rd_ptr_q];
    assign ifu_idu_inst          = fifo_inst[rd_ptr_q];
    assign ifu_idu_predict_taken = fifo_taken[rd_ptr_q];
    assign ifu_idu_predict_pc    = fifo_ppc[rd_ptr_q];

    assign pop         = ifu_idu_valid & idu_ifu_ready;
    assign count_after = count_q + {1'b0, push} - {1'b0, pop};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (grant)
                    state_d = alu_ifu_redirect ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (alu_ifu_redirect)
                    state_d = imem_ifu_rvalid ? S_REQ : S_DRAIN;
                else if (imem_ifu_rvalid)
                    state_d = (count_after < FIFO_FULL) ? S_REQ : S_STALL;
            end
            S_STALL: begin
                if (alu_ifu_redirect || (count_after < FIFO_FULL))
                    state_d = S_REQ;
            end
            S_DRAIN: begin
                if (imem_ifu_rvalid)
                    state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            capture_q <= 1'b0;
            count_q   <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            // A lookup killed by a redirect in its grant cycle must not later
            // overwrite the redirect PC with a stale prediction.
            capture_q <= grant & ~alu_ifu_redirect;
            if (alu_ifu_redirect)
                pc_q <= alu_ifu_redirect_pc & ~64'd3;
            else if (capture_q)
                pc_q <= bpu_ifu_next_pc;

            if (alu_ifu_redirect) begin
                count_q  <= 2'd0;
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                count_q <= count_after;
                if (push)
                    wr_ptr_q <= ~wr_ptr_q;
                if (pop)
                    rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Datapath registers carry no reset; every use is qualified by state or count.
    always_ff @(posedge clk) begin
        if (grant)
            fetch_pc_q <= pc_q;
        if (capture_q) begin
            side_taken_q <= bpu_ifu_predict_taken;
            side_ppc_q   <= bpu_ifu_predict_pc;
        end
        if (push && !rstn) begin
            fifo_pc[wr_ptr_q]    <= fetch_pc_q;
            fifo_inst[wr_ptr_q]  <= imem_ifu_rdata;
            fifo_taken[wr_ptr_q] <= push_taken;
            fifo_ppc[wr_ptr_q]   <= push_ppc;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: directed bench for ifu_fetch_ctrl.
// The memory model answers every granted request two cycles later with
// ~addr[31:0]. The BPU model returns lookup PC + 4 unless overridden.
module tb_ifu_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [63:0] bpu_ifu_next_pc;
    logic        bpu_ifu_predict_taken = 1'b0;
    logic [63:0] bpu_ifu_predict_pc = 64'd0;
    logic        alu_ifu_redirect = 1'b0;
    logic [63:0] alu_ifu_redirect_pc = 64'd0;
    logic        imem_ifu_gnt = 1'b1;
    logic        imem_ifu_rvalid;
    logic [31:0] imem_ifu_rdata;
    logic        idu_ifu_ready = 1'b0;
    logic        ifu_bpu_pc_valid;
    logic [63:0] ifu_bpu_pc;
    logic        ifu_bpu_hit_vld;
    logic        ifu_imem_req;
    logic [63:0] ifu_imem_addr;
    logic        ifu_idu_valid;
    logic [63:0] ifu_idu_pc;
    logic [31:0] ifu_idu_inst;
    logic        ifu_idu_predict_taken;
    logic [63:0] ifu_idu_predict_pc;

    int checks = 0;
    int failures = 0;

    logic        rv_s1 = 1'b0, rv_s2 = 1'b0;
    logic [31:0] rd_s1 = 32'd0, rd_s2 = 32'd0;
    logic [63:0] auto_next = 64'd0;
    logic        next_ovr = 1'b0;
    logic [63:0] man_next = 64'd0;

    assign imem_ifu_rvalid = rv_s2;
    assign imem_ifu_rdata  = rd_s2;
    assign bpu_ifu_next_pc = next_ovr ? man_next : auto_next;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rv_s1 <= ifu_imem_req & imem_ifu_gnt;
        rd_s1 <= ~ifu_imem_addr[31:0];
        rv_s2 <= rv_s1;
        rd_s2 <= rd_s1;
        if (ifu_bpu_pc_valid)
            auto_next <= ifu_bpu_pc + 64'd4;
    end

    ifu_fetch_ctrl dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .bpu_ifu_next_pc       (bpu_ifu_next_pc),
        .bpu_ifu_predict_taken (bpu_ifu_predict_taken),
        .bpu_ifu_predict_pc    (bpu_ifu_predict_pc),
        .alu_ifu_redirect      (alu_ifu_redirect),
        .alu_ifu_redirect_pc   (alu_ifu_redirect_pc),
        .imem_ifu_gnt          (imem_ifu_gnt),
        .imem_ifu_rvalid       (imem_ifu_rvalid),
        .imem_ifu_rdata        (imem_ifu_rdata),
        .idu_ifu_ready         (idu_ifu_ready),
        .ifu_bpu_pc_valid      (ifu_bpu_pc_valid),
        .ifu_bpu_pc            (ifu_bpu_pc),
        .ifu_bpu_hit_vld       (ifu_bpu_hit_vld),
        .ifu_imem_req          (ifu_imem_req),
        .ifu_imem_addr         (ifu_imem_addr),
        .ifu_idu_valid         (ifu_idu_valid),
        .ifu_idu_pc            (ifu_idu_pc),
        .ifu_idu_inst          (ifu_idu_inst),
        .ifu_idu_predict_taken (ifu_idu_predict_taken),
        .ifu_idu_predict_pc    (ifu_idu_predict_pc)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle with reset released (cycle 0).
    task automatic reset_dut();
        rstn = 1'b1;
        alu_ifu_redirect = 1'b0;
        next_ovr = 1'b0;
        bpu_ifu_predict_taken = 1'b0;
        bpu_ifu_predict_pc = 64'd0;
        repeat (3) tick();
        rstn = 1'b0;
    endtask

    initial begin
        int grants, hits, pops;
        logic [63:0] first_addr;

        // reset: outputs forced low even with gnt high
        tick();
        tick();
        #3;
        chk("rst_req", ifu_imem_req, 1'b0);
        chk("rst_pc_valid", ifu_bpu_pc_valid, 1'b0);
        chk("rst_hit", ifu_bpu_hit_vld, 1'b0);
        chk("rst_idu_valid", ifu_idu_valid, 1'b0);

        // sequential fetch, decode always ready
        reset_dut();
        idu_ifu_ready = 1'b1;
        grants = 0; hits = 0; pops = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            #3;
            if (c == 0) begin
                chk("a_bpu_valid", ifu_bpu_pc_valid, 1'b1);
                chk("a_bpu_pc", ifu_bpu_pc, 64'h8000_0000);
            end
            if (ifu_imem_req) begin
                chk("a_addr", ifu_imem_addr, 64'h8000_0000 + 64'(4 * grants));
                grants++;
            end
            if (ifu_bpu_hit_vld) hits++;
            if (ifu_idu_valid) begin
                chk("a_idu_pc", ifu_idu_pc, 64'h8000_0000 + 64'(4 * pops));
                chk("a_idu_inst", {32'd0, ifu_idu_inst}, {32'd0, ~(32'h8000_0000 + 32'(4 * pops))});
                chk("a_idu_taken", ifu_idu_predict_taken, 1'b0);
                chk("a_pop_cycle", 64'(c), 64'(3 * (pops + 1)));
                pops++;
            end
        end
        chk("a_grants", 64'(grants), 64'd4);
        chk("a_hits", 64'(hits), 64'd3);
        chk("a_pops", 64'(pops), 64'd3);

        // decode stalled: buffer fills, requests stop
        reset_dut();
        idu_ifu_ready = 1'b0;
        grants = 0;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) tick();
            #3;
            if (ifu_imem_req) grants++;
        end
        chk("b_grants_full", 64'(grants), 64'd2);
        chk("b_stall_req", ifu_imem_req, 1'b0);
        chk("b_head_valid", ifu_idu_valid, 1'b1);
        chk("b_head_pc", ifu_idu_pc, 64'h8000_0000);
        tick();
        idu_ifu_ready = 1'b1;
        #3;
        chk("b_pop_valid", ifu_idu_valid, 1'b1);
        chk("b_stall_req2", ifu_imem_req, 1'b0);
        grants = 0;
        first_addr = 64'd0;
        for (int c = 0; c < 6; c++) begin
            tick();
            idu_ifu_ready = 1'b0;
            #3;
            if (ifu_imem_req) begin
                if (grants == 0) first_addr = ifu_imem_addr;
                grants++;
            end
        end
        chk("b_one_more", 64'(grants), 64'd1);
        chk("b_more_addr", first_addr, 64'h8000_0008);
        chk("b_head_pc2", ifu_idu_pc, 64'h8000_0004);

        // redirect while WAIT, response then dropped in DRAIN
        reset_dut();
        idu_ifu_ready = 1'b0;
        tick(); tick(); tick();
        #3;
        chk("c_pre_valid", ifu_idu_valid, 1'b1);
        tick();
        alu_ifu_redirect = 1'b1;
        alu_ifu_redirect_pc = 64'h8000_1002;
        #3;
        chk("c_redir_valid", ifu_idu_valid, 1'b0);
        tick();
        alu_ifu_redirect = 1'b0;
        #3;
        chk("c_drain_req", ifu_imem_req, 1'b0);
        chk("c_drain_hit", ifu_bpu_hit_vld, 1'b0);
        chk("c_drain_valid", ifu_idu_valid, 1'b0);
        tick();
        #3;
        chk("c_new_req", ifu_imem_req, 1'b1);
        chk("c_new_addr", ifu_imem_addr, 64'h8000_1000);
        chk("c_new_valid", ifu_idu_valid, 1'b0);

        // redirect in the same cycle as rvalid
        reset_dut();
        idu_ifu_ready = 1'b0;
        tick(); tick();
        alu_ifu_redirect = 1'b1;
        alu_ifu_redirect_pc = 64'h8000_2000;
        #3;
        chk("d_hit", ifu_bpu_hit_vld, 1'b0);
        tick();
        alu_ifu_redirect = 1'b0;
        #3;
        chk("d_req", ifu_imem_req, 1'b1);
        chk("d_addr", ifu_imem_addr, 64'h8000_2000);
        chk("d_valid", ifu_idu_valid, 1'b0);

        // taken prediction held in the side register across the wait
        reset_dut();
        idu_ifu_ready = 1'b0;
        tick();
        next_ovr = 1'b1;
        man_next = 64'h8000_0100;
        bpu_ifu_predict_taken = 1'b1;
        bpu_ifu_predict_pc = 64'h8000_0100;
        tick();
        man_next = 64'd0;
        bpu_ifu_predict_taken = 1'b0;
        bpu_ifu_predict_pc = 64'd0;
        #3;
        chk("e_hit", ifu_bpu_hit_vld, 1'b1);
        tick();
        #3;
        chk("e_addr", ifu_imem_addr, 64'h8000_0100);
        chk("e_valid", ifu_idu_valid, 1'b1);
        chk("e_idu_pc", ifu_idu_pc, 64'h8000_0000);
        chk("e_taken", ifu_idu_predict_taken, 1'b1);
        chk("e_ppc", ifu_idu_predict_pc, 64'h8000_0100);
        next_ovr = 1'b0;

        // reset mid-WAIT with one buffered entry; late rvalid ignored
        reset_dut();
        idu_ifu_ready = 1'b0;
        tick(); tick(); tick();
        #3;
        chk("f_pre_valid", ifu_idu_valid, 1'b1);
        tick();
        rstn = 1'b1;
        #3;
        chk("f_rst_req", ifu_imem_req, 1'b0);
        chk("f_rst_valid", ifu_idu_valid, 1'b0);
        chk("f_rst_pcv", ifu_bpu_pc_valid, 1'b0);
        chk("f_rst_hit", ifu_bpu_hit_vld, 1'b0);
        tick();
        rstn = 1'b0;
        #3;
        chk("f_req", ifu_imem_req, 1'b1);
        chk("f_addr", ifu_imem_addr, 64'h8000_0000);
        chk("f_late_hit", ifu_bpu_hit_vld, 1'b0);
        tick();
        #3;
        chk("f_late_valid", ifu_idu_valid, 1'b0);
        tick();
        #3;
        chk("f_hit", ifu_bpu_hit_vld, 1'b1);
        tick();
        #3;
        chk("f_valid", ifu_idu_valid, 1'b1);
        chk("f_idu_pc", ifu_idu_pc, 64'h8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
